// File: rtl/cache_line_mover.sv
// Line-transfer engine between the direct-mapped cache data array and RAM: optional writeback, then beat-wise fill.
// Optional fill watchdog is compiled in when CACHE_LINE_MOVER_TIMEOUT_EN is defined.
module cache_line_mover #(
  parameter int LINE_W         = 128,
  parameter int BEAT_W         = 32,
  parameter int IDX_W          = 10,
  parameter int LADDR_W        = 22,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic               globalclock,
  input  logic               reset,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_evict,
  input  logic [IDX_W-1:0]   req_index,
  input  logic [LADDR_W-1:0] req_evict_addr,
  input  logic [LADDR_W-1:0] req_fill_addr,
  output logic               done,
  output logic               err,
  output logic [IDX_W-1:0]   cdm_address,
  output logic               cdm_wrEn,
  output logic [LINE_W-1:0]  cdm_inData,
  input  logic [LINE_W-1:0]  cdm_outData,
  output logic               ram_cmd_valid,
  input  logic               ram_cmd_ready,
  output logic               ram_cmd_write,
  output logic [LADDR_W-1:0] ram_cmd_addr,
  output logic               ram_wdata_valid,
  input  logic               ram_wdata_ready,
  output logic [BEAT_W-1:0]  ram_wdata,
  input  logic               ram_rdata_valid,
  input  logic [BEAT_W-1:0]  ram_rdata
);

  localparam int BEATS = LINE_W / BEAT_W;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_EVICT_CMD,
    S_EVICT_DATA,
    S_FILL_CMD,
    S_FILL_DATA,
    S_FILL_WRITE,
    S_DONE
  } state_e;

  state_e                         state_q, state_d;
  logic [CNT_W-1:0]               cnt_q, cnt_d;
  logic [BEATS-1:0][BEAT_W-1:0]   line_q, line_d;
  logic [IDX_W-1:0]               idx_q, idx_d;
  logic [LADDR_W-1:0]             eaddr_q, eaddr_d;
  logic [LADDR_W-1:0]             faddr_q, faddr_d;
  logic                           timeout;

`ifdef CACHE_LINE_MOVER_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [WD_W-1:0] wdog_q, wdog_d;
  logic            err_q, err_d;

  // Watchdog counts consecutive idle cycles in FILL_DATA; any beat restarts it.
  assign timeout = (state_q == S_FILL_DATA) && !ram_rdata_valid &&
                   (wdog_q == WD_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    wdog_d = wdog_q;
    err_d  = err_q;
    if (state_q == S_IDLE) err_d = 1'b0;
    if ((state_q != S_FILL_DATA) || ram_rdata_valid) begin
      wdog_d = '0;
    end else if (timeout) begin
      wdog_d = '0;
      err_d  = 1'b1;
    end else begin
      wdog_d = wdog_q + 1'b1;
    end
  end

  always_ff @(posedge globalclock or posedge reset) begin
    if (reset) begin
      wdog_q <= '0;
      err_q  <= 1'b0;
    end else begin
      wdog_q <= wdog_d;
      err_q  <= err_d;
    end
  end

  assign err = (state_q == S_DONE) && err_q;
`else
  assign timeout = 1'b0;
  assign err     = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    line_d  = line_q;
    idx_d   = idx_q;
    eaddr_d = eaddr_q;
    faddr_d = faddr_q;
    unique case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          idx_d   = req_index;
          eaddr_d = req_evict_addr;
          faddr_d = req_fill_addr;
          state_d = req_evict ? S_EVICT_CMD : S_FILL_CMD;
        end
      end
      S_EVICT_CMD: begin
        // Snapshot the resident line now, before the fill can overwrite the same index.
        if (ram_cmd_ready) begin
          line_d  = cdm_outData;
          cnt_d   = '0;
          state_d = S_EVICT_DATA;
        end
      end
      S_EVICT_DATA: begin
        if (ram_wdata_ready) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST_BEAT) state_d = S_FILL_CMD;
        end
      end
      S_FILL_CMD: begin
        if (ram_cmd_ready) begin
          cnt_d   = '0;
          state_d = S_FILL_DATA;
        end
      end
      S_FILL_DATA: begin
        if (ram_rdata_valid) begin
          line_d[cnt_q] = ram_rdata;
          cnt_d         = cnt_q + 1'b1;
          if (cnt_q == LAST_BEAT) state_d = S_FILL_WRITE;
        end else if (timeout) begin
          state_d = S_DONE;
        end
      end
      S_FILL_WRITE: state_d = S_DONE;
      S_DONE:       state_d = S_IDLE;
      default:      state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge globalclock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      line_q  <= '0;
      idx_q   <= '0;
      eaddr_q <= '0;
      faddr_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      line_q  <= line_d;
      idx_q   <= idx_d;
      eaddr_q <= eaddr_d;
      faddr_q <= faddr_d;
    end
  end

  // Outputs decode from state and registers only, so reset clears them asynchronously.
  assign req_ready       = (state_q == S_IDLE);
  assign done            = (state_q == S_DONE);
  assign cdm_wrEn        = (state_q == S_FILL_WRITE);
  assign cdm_address     = idx_q;
  assign cdm_inData      = line_q;
  assign ram_cmd_valid   = (state_q == S_EVICT_CMD) || (state_q == S_FILL_CMD);
  assign ram_cmd_write   = (state_q == S_EVICT_CMD);
  assign ram_cmd_addr    = (state_q == S_EVICT_CMD) ? eaddr_q :
                           (state_q == S_FILL_CMD)  ? faddr_q : '0;
  assign ram_wdata_valid = (state_q == S_EVICT_DATA);
  assign ram_wdata       = (state_q == S_EVICT_DATA) ? line_q[cnt_q] : '0;

endmodule

// File: tb/tb_cache_line_mover.sv
// Self-checking bench for cache_line_mover: directed vector table, reset/timeout sequences, randomized transactions.
module tb_cache_line_mover;
  localparam int LINE_W  = 128;
  localparam int BEAT_W  = 32;
  localparam int IDX_W   = 10;
  localparam int LADDR_W = 22;
  localparam int TO      = 8;

  logic               globalclock = 1'b0;
  logic               reset = 1'b0;
  logic               req_valid = 1'b0, req_ready, req_evict = 1'b0;
  logic [IDX_W-1:0]   req_index = '0;
  logic [LADDR_W-1:0] req_evict_addr = '0, req_fill_addr = '0;
  logic               done, err;
  logic [IDX_W-1:0]   cdm_address;
  logic               cdm_wrEn;
  logic [LINE_W-1:0]  cdm_inData, cdm_outData;
  logic               ram_cmd_valid, ram_cmd_ready = 1'b0, ram_cmd_write;
  logic [LADDR_W-1:0] ram_cmd_addr;
  logic               ram_wdata_valid, ram_wdata_ready = 1'b0;
  logic [BEAT_W-1:0]  ram_wdata;
  logic               ram_rdata_valid = 1'b0;
  logic [BEAT_W-1:0]  ram_rdata = '0;

  logic [LINE_W-1:0] cache_mem [0:1023];
  logic [LINE_W-1:0] ref_cache [0:1023];
  int checks = 0;
  int errors = 0;
  int wr_count = 0;

  typedef struct {
    logic               ev;
    logic [IDX_W-1:0]   idx;
    logic [LADDR_W-1:0] ea;
    logic [LADDR_W-1:0] fa;
    logic               pre_en;
    logic [LINE_W-1:0]  pre;
    logic [LINE_W-1:0]  fill;
    logic [LINE_W-1:0]  exp_wb;
    int                 cstall;
    int                 wstall;
    int                 rgap;
  } vec_t;
  vec_t vecs [5];

  cache_line_mover #(
    .LINE_W(LINE_W), .BEAT_W(BEAT_W), .IDX_W(IDX_W), .LADDR_W(LADDR_W), .TIMEOUT_CYCLES(TO)
  ) dut (
    .globalclock(globalclock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_evict(req_evict),
    .req_index(req_index), .req_evict_addr(req_evict_addr), .req_fill_addr(req_fill_addr),
    .done(done), .err(err),
    .cdm_address(cdm_address), .cdm_wrEn(cdm_wrEn), .cdm_inData(cdm_inData), .cdm_outData(cdm_outData),
    .ram_cmd_valid(ram_cmd_valid), .ram_cmd_ready(ram_cmd_ready), .ram_cmd_write(ram_cmd_write),
    .ram_cmd_addr(ram_cmd_addr),
    .ram_wdata_valid(ram_wdata_valid), .ram_wdata_ready(ram_wdata_ready), .ram_wdata(ram_wdata),
    .ram_rdata_valid(ram_rdata_valid), .ram_rdata(ram_rdata)
  );

  always #5 globalclock = ~globalclock;

  assign cdm_outData = cache_mem[cdm_address];

  always @(posedge globalclock) if (cdm_wrEn === 1'b1) wr_count <= wr_count + 1;

  task automatic check(input string name, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic cmd_phase(input logic wr, input logic [LADDR_W-1:0] a, input int stall);
    for (int s = 0; s <= stall; s++) begin
      ram_cmd_ready = (s == stall);
      check("cmd_valid", ram_cmd_valid, 1'b1);
      check("cmd_write", ram_cmd_write, wr);
      check("cmd_addr", ram_cmd_addr, a);
      check("no_wbeat_in_cmd", ram_wdata_valid, 1'b0);
      @(negedge globalclock);
    end
    ram_cmd_ready = 1'b0;
  endtask

  task automatic issue_req(input logic ev, input logic [IDX_W-1:0] idx,
                           input logic [LADDR_W-1:0] ea, input logic [LADDR_W-1:0] fa);
    check("req_ready_idle", req_ready, 1'b1);
    req_valid = 1'b1; req_evict = ev; req_index = idx; req_evict_addr = ea; req_fill_addr = fa;
    @(negedge globalclock);
    req_valid = 1'b0; req_evict = 1'($urandom); req_index = IDX_W'($urandom);
    req_evict_addr = LADDR_W'($urandom); req_fill_addr = LADDR_W'($urandom);
    check("req_ready_busy", req_ready, 1'b0);
  endtask

  task automatic run_txn(input logic ev, input logic [IDX_W-1:0] idx,
                         input logic [LADDR_W-1:0] ea, input logic [LADDR_W-1:0] fa,
                         input logic [LINE_W-1:0] fill, input logic [LINE_W-1:0] exp_wb,
                         input int cstall, input int wstall, input int rgap);
    int wr0;
    issue_req(ev, idx, ea, fa);
    wr0 = wr_count;
    if (ev) begin
      cmd_phase(1'b1, ea, cstall);
      for (int b = 0; b < 4; b++) begin
        for (int s = 0; s <= wstall; s++) begin
          ram_wdata_ready = (s == wstall);
          ram_rdata_valid = 1'($urandom);
          ram_rdata = $urandom;
          check("wbeat_valid", ram_wdata_valid, 1'b1);
          check("wbeat_data", ram_wdata, exp_wb[b*BEAT_W +: BEAT_W]);
          check("no_cmd_in_wbeat", ram_cmd_valid, 1'b0);
          @(negedge globalclock);
        end
        ram_wdata_ready = 1'b0;
        ram_rdata_valid = 1'b0;
      end
    end
    cmd_phase(1'b0, fa, cstall);
    for (int b = 0; b < 4; b++) begin
      for (int g = 0; g < rgap; g++) begin
        check("no_early_write", cdm_wrEn, 1'b0);
        @(negedge globalclock);
      end
      ram_rdata_valid = 1'b1;
      ram_rdata = fill[b*BEAT_W +: BEAT_W];
      @(negedge globalclock);
      ram_rdata_valid = 1'b0;
      ram_rdata = $urandom;
    end
    check("cdm_wrEn", cdm_wrEn, 1'b1);
    check("cdm_address", cdm_address, idx);
    check("cdm_inData", cdm_inData, fill);
    check("done_early", done, 1'b0);
    if (cdm_wrEn === 1'b1) cache_mem[cdm_address] = cdm_inData;
    @(negedge globalclock);
    check("done_pulse", done, 1'b1);
    check("err_on_done", err, 1'b0);
    check("wrEn_single", cdm_wrEn, 1'b0);
    check("req_ready_in_done", req_ready, 1'b0);
    @(negedge globalclock);
    check("done_cleared", done, 1'b0);
    check("req_ready_back", req_ready, 1'b1);
    check("write_count", wr_count - wr0, 1);
    ref_cache[idx] = fill;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"}, req_ready, 1'b1);
    check({tag, "_cdm_wrEn"}, cdm_wrEn, 1'b0);
    check({tag, "_done"}, done, 1'b0);
    check({tag, "_err"}, err, 1'b0);
    check({tag, "_cmd_valid"}, ram_cmd_valid, 1'b0);
    check({tag, "_cmd_addr"}, ram_cmd_addr, '0);
    check({tag, "_wdata_valid"}, ram_wdata_valid, 1'b0);
    check({tag, "_cdm_address"}, cdm_address, '0);
    check({tag, "_cdm_inData"}, cdm_inData, '0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    int wr0;
    logic [LINE_W-1:0] fl;
    logic              ev;
    logic [IDX_W-1:0]  ix;

    for (int i = 0; i < 1024; i++) begin
      cache_mem[i] = {$urandom, $urandom, $urandom, $urandom};
      ref_cache[i] = cache_mem[i];
    end

    vecs[0] = '{1'b0, 10'h005, 22'h000000, 22'h000123, 1'b0, 128'h0,
                128'h44444444_33333333_22222222_11111111, 128'h0, 0, 0, 0};
    vecs[1] = '{1'b1, 10'h3FF, 22'h0000FF, 22'h02A5A5, 1'b1,
                128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA,
                128'h01234567_89ABCDEF_0F1E2D3C_4B5A6978,
                128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA, 0, 2, 0};
    vecs[2] = '{1'b0, 10'h0AB, 22'h000000, 22'h3FFFFF, 1'b0, 128'h0,
                128'hFEEDFACE_DEADBEEF_00000000_FFFFFFFF, 128'h0, 5, 0, 1};
    vecs[3] = '{1'b1, 10'h005, 22'h000123, 22'h000456, 1'b0, 128'h0,
                128'hCAFEBABE_12345678_9ABCDEF0_55AA55AA,
                128'h44444444_33333333_22222222_11111111, 5, 1, 2};
    vecs[4] = '{1'b1, 10'h000, 22'h3FFFFF, 22'h000000, 1'b1, {LINE_W{1'b1}},
                128'h0, {LINE_W{1'b1}}, 1, 0, 3};

    #2 reset = 1'b1;
    #1 check_reset_outputs("reset_async");
    repeat (2) @(negedge globalclock);
    reset = 1'b0;
    @(negedge globalclock);
    check_reset_outputs("idle");

    for (int v = 0; v < 5; v++) begin
      if (vecs[v].pre_en) begin
        cache_mem[vecs[v].idx] = vecs[v].pre;
        ref_cache[vecs[v].idx] = vecs[v].pre;
      end
      run_txn(vecs[v].ev, vecs[v].idx, vecs[v].ea, vecs[v].fa, vecs[v].fill, vecs[v].exp_wb,
              vecs[v].cstall, vecs[v].wstall, vecs[v].rgap);
    end

    // Reset after two fill beats must abort without touching the cache.
    wr0 = wr_count;
    issue_req(1'b0, 10'h077, 22'h000000, 22'h000001);
    cmd_phase(1'b0, 22'h000001, 0);
    for (int b = 0; b < 2; b++) begin
      ram_rdata_valid = 1'b1;
      ram_rdata = $urandom;
      @(negedge globalclock);
    end
    ram_rdata_valid = 1'b0;
    reset = 1'b1;
    #1 check_reset_outputs("midop_reset");
    @(negedge globalclock);
    reset = 1'b0;
    @(negedge globalclock);
    check("midop_no_write", wr_count - wr0, 0);
    run_txn(1'b1, 10'h077, 22'h000077, 22'h000078, 128'h77777777_66666666_55555555_44444444,
            ref_cache[10'h077], 0, 0, 0);

`ifdef CACHE_LINE_MOVER_TIMEOUT_EN
    begin
      int n;
      wr0 = wr_count;
      issue_req(1'b0, 10'h010, 22'h000000, 22'h000200);
      cmd_phase(1'b0, 22'h000200, 0);
      n = 0;
      while (done !== 1'b1 && n < 50) begin
        @(negedge globalclock);
        n++;
      end
      check("timeout_cycles", n, TO);
      check("timeout_err", err, 1'b1);
      check("timeout_no_write", wr_count - wr0, 0);
      @(negedge globalclock);
      check("timeout_err_cleared", err, 1'b0);
      check("timeout_idle", req_ready, 1'b1);
    end
`endif

    for (int t = 0; t < 40; t++) begin
      ev = 1'($urandom);
      ix = IDX_W'($urandom_range(0, 7));
      fl = {$urandom, $urandom, $urandom, $urandom};
      run_txn(ev, ix, LADDR_W'($urandom), LADDR_W'($urandom), fl, ref_cache[ix],
              $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
    end

    for (int i = 0; i < 8; i++) check("cache_content", cache_mem[i], ref_cache[i]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
